// File: rtl/serial_comparator_d_i.sv
// Bit-serial LSB-first A > B comparator; one operand bit pair per RUN cycle.
// Optional A == B output enabled by defining COMP_EQ_EN.
module serial_comparator_d_i #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
`ifdef COMP_EQ_EN
    output logic         eq,
`endif
    output logic         z
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  sa_q, sa_d;
    logic [N-1:0]  sb_q, sb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          y_q, y_d;
    logic          z_q, z_d;
`ifdef COMP_EQ_EN
    logic          e_q, e_d;
    logic          eq_q, eq_d;
`endif

    logic ai, bi, y_nxt;

    assign ai    = sa_q[0];
    assign bi    = sb_q[0];
    // y = 1 means A <= B over the bits consumed so far
    assign y_nxt = (y_q & ~ai) | (y_q & bi) | (~ai & bi);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            y_q     <= 1'b0;
            z_q     <= 1'b0;
`ifdef COMP_EQ_EN
            e_q     <= 1'b0;
            eq_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            z_q     <= z_d;
`ifdef COMP_EQ_EN
            e_q     <= e_d;
            eq_q    <= eq_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        z_d     = z_q;
`ifdef COMP_EQ_EN
        e_d     = e_q;
        eq_d    = eq_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    y_d     = 1'b1;
                    cnt_d   = '0;
`ifdef COMP_EQ_EN
                    e_d     = 1'b1;
`endif
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    // MSB cell resolves the final strict comparison
                    z_d     = (ai & ~bi) | (~y_q & ~bi) | (~y_q & ai);
`ifdef COMP_EQ_EN
                    eq_d    = e_q & (ai ~^ bi);
`endif
                    state_d = DONE;
                end else begin
                    y_d   = y_nxt;
                    sa_d  = sa_q >> 1;
                    sb_d  = sb_q >> 1;
                    cnt_d = cnt_q + 1'b1;
`ifdef COMP_EQ_EN
                    e_d   = e_q & (ai ~^ bi);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign z    = z_q;
`ifdef COMP_EQ_EN
    assign eq   = eq_q;
`endif

endmodule

// File: tb/tb_serial_comparator_d_i.sv
// Scoreboard bench for serial_comparator_d_i at N=3 and N=8.
// Expected results come from plain unsigned arithmetic on the operands.
module tb_serial_comparator_d_i;

    logic clk = 1'b0;
    logic reset;

    logic       start3, busy3, done3, z3;
    logic [2:0] a3, b3;
    logic       start8, busy8, done8, z8;
    logic [7:0] a8, b8;
`ifdef COMP_EQ_EN
    logic       eq3, eq8;
`endif

    always #5 clk = ~clk;

    serial_comparator_d_i #(.N(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3),
        .a(a3), .b(b3), .busy(busy3), .done(done3),
`ifdef COMP_EQ_EN
        .eq(eq3),
`endif
        .z(z3)
    );

    serial_comparator_d_i #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8),
        .a(a8), .b(b8), .busy(busy8), .done(done8),
`ifdef COMP_EQ_EN
        .eq(eq8),
`endif
        .z(z8)
    );

    typedef struct {
        logic z;
        logic eq;
    } exp_t;

    exp_t q3[$];
    exp_t q8[$];
    exp_t e3, e8;
    int checks = 0;
    int passed = 0;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    always @(negedge clk) begin
        if (done3) begin
            chk("done3_pending", int'(q3.size() != 0), 1);
            if (q3.size() != 0) begin
                e3 = q3.pop_front();
                chk("z3", int'(z3), int'(e3.z));
`ifdef COMP_EQ_EN
                chk("eq3", int'(eq3), int'(e3.eq));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (done8) begin
            chk("done8_pending", int'(q8.size() != 0), 1);
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                chk("z8", int'(z8), int'(e8.z));
`ifdef COMP_EQ_EN
                chk("eq8", int'(eq8), int'(e8.eq));
`endif
            end
        end
    end

    task automatic issue3(input logic [2:0] a, input logic [2:0] b,
                          output int lat);
        @(negedge clk);
        a3 = a; b3 = b; start3 = 1'b1;
        q3.push_back('{z: (a > b), eq: (a == b)});
        @(posedge clk);
        #1 start3 = 1'b0;
        a3 = 3'($urandom); b3 = 3'($urandom);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done3) begin
                lat = k;
                break;
            end
            chk("busy3_run", int'(busy3), 1);
        end
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          output int lat);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        q8.push_back('{z: (a > b), eq: (a == b)});
        @(posedge clk);
        #1 start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done8) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat, dcnt;

    initial begin
        reset = 1'b1;
        start3 = 1'b0; a3 = '0; b3 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy3), 0);
        chk("rst_done", int'(done3), 0);
        chk("rst_z", int'(z3), 0);
`ifdef COMP_EQ_EN
        chk("rst_eq", int'(eq3), 0);
`endif
        reset = 1'b0;

        issue3(3'd5, 3'd3, lat); chk("lat_5_3", lat, 4);
        issue3(3'd3, 3'd5, lat); chk("lat_3_5", lat, 4);
        issue3(3'd6, 3'd6, lat); chk("lat_6_6", lat, 4);

        // start while busy must be ignored
        @(negedge clk);
        a3 = 3'd7; b3 = 3'd0; start3 = 1'b1;
        q3.push_back('{z: 1'b1, eq: 1'b0});
        @(posedge clk);
        #1 start3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a3 = 3'd0; b3 = 3'd7; start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done3) dcnt++;
        end
        chk("ignore_one_done", dcnt, 1);

        // start held through the done cycle
        @(negedge clk);
        a3 = 3'd2; b3 = 3'd3; start3 = 1'b1;
        q3.push_back('{z: 1'b0, eq: 1'b0});
        @(posedge clk);
        #1 a3 = 3'd1; b3 = 3'd0;
        q3.push_back('{z: 1'b1, eq: 1'b0});
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done3) begin lat = k; break; end
        end
        chk("b2b_first_lat", lat, 4);
        @(posedge clk);
        #1 start3 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done3) begin lat = k; break; end
        end
        chk("b2b_second_gap", lat, 4);

        // reset during the second RUN cycle aborts the request
        @(negedge clk);
        a3 = 3'd7; b3 = 3'd0; start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", int'(busy3), 0);
        chk("abort_done", int'(done3), 0);
        chk("abort_z", int'(z3), 0);
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done3) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);

        for (int i = 0; i < 30; i++) begin
            issue3(3'($urandom), 3'($urandom), lat);
            chk("rand3_lat", lat, 4);
        end

        issue8(8'h80, 8'h7F, lat); chk("lat8_80_7f", lat, 9);
        issue8(8'h7F, 8'h80, lat); chk("lat8_7f_80", lat, 9);
        issue8(8'hA5, 8'hA5, lat); chk("lat8_eq", lat, 9);
        for (int i = 0; i < 20; i++) begin
            issue8(8'($urandom), 8'($urandom), lat);
            chk("rand8_lat", lat, 9);
        end

        repeat (3) @(negedge clk);
        chk("q3_drained", q3.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
